mcycle_unit: RTL
================

# mcycle_unit

Iterative multi-cycle multiply/divide unit in the execute stage, beside the ALU. Operand2 is the shifter output (ShOut), so register-shifted operands are multiplied or divided exactly as the ALU would see them. The unit holds Busy while iterating so the pipeline can stall. It returns a 2W-bit product or a quotient/remainder pair.

## Interface
- WIDTH, 32, operand and result width in bits.
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- Start  input  1  request an operation; sampled only in IDLE.
- MCycleOp  input  2  operation select:
  - 00 signed multiply
  - 01 unsigned multiply
  - 10 signed divide
  - 11 unsigned divide
- Operand1  input  WIDTH  multiplicand or dividend.
- Operand2  input  WIDTH  multiplier or divisor (shifter output).
- Result1  output  WIDTH  product low half, or quotient.
- Result2  output  WIDTH  product high half, or remainder.
- Busy  output  1  operation in progress; the pipeline stalls while high.

## Operation
- States: IDLE and COMPUTING. Reset forces IDLE, count=0, Result1=0, Result2=0.
- IDLE with Start=1:
  - latch MCycleOp, |Operand1|, |Operand2| and the result signs;
  - magnitudes are taken only for signed ops; unsigned ops latch raw values;
  - clear the accumulator and count; go to COMPUTING.
- COMPUTING, multiply: radix-2 shift-and-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- COMPUTING, divide: restoring division, one quotient bit per cycle; partial remainder is WIDTH+1 bits.
- The count increments each COMPUTING cycle. When count==WIDTH-1:
  - apply the sign fix: negate the product if the operand signs differ;
  - negate the quotient if the signs differ; the remainder takes the dividend's sign;
  - write Result1/Result2; go to IDLE.
- Signed divide truncates toward zero.
- Divide by zero (Operand2==0), signed or unsigned:
  - Result1=all ones, Result2=Operand1 (raw value);
  - still takes the full WIDTH iterations.
- Signed overflow, most-negative / −1: Result1=0x80000000, Result2=0, with no special casing.
- Result1/Result2 are registered and hold their value until the next operation completes or RESET.
- Start in COMPUTING is ignored. Operand and MCycleOp changes after the launch cycle have no effect.

## Timing
- Busy = (IDLE & Start) | COMPUTING. It is combinational, so Busy rises in the same cycle as Start.
- Latency: Start sampled at edge 0. Results are valid after edge WIDTH, i.e. from cycle WIDTH+1.
- Busy is high for cycles 0..WIDTH inclusive (WIDTH+1 cycles) and low in cycle WIDTH+1.
- Back-to-back: Start=1 in the first IDLE cycle launches the next op. The previous results are visible in that cycle.
- RESET has priority over everything:
  - mid-operation it aborts to IDLE, zeroes the results and drops Busy in the following cycle;
  - RESET=1 with Start=1 does not launch.
- No output depends combinationally on Operand1, Operand2 or MCycleOp.

## Test plan
- Signed multiply, −3 × 7 (Operand1=0xFFFFFFFD, Operand2=0x00000007), op 00:
  - Result1=0xFFFFFFEB, Result2=0xFFFFFFFF;
  - Busy high for exactly 33 cycles from Start.
- Unsigned multiply, 0xFFFFFFFF × 0x00000002, op 01: Result1=0xFFFFFFFE, Result2=0x00000001.
- Divides:
  - unsigned 100 / 7 (op 11) → Result1=14, Result2=2;
  - signed −7 / 2 (op 10) → Result1=0xFFFFFFFD, Result2=0xFFFFFFFF;
  - signed 0x80000000 / 0xFFFFFFFF → Result1=0x80000000, Result2=0.
- Divide by zero, 0x12345678 / 0 (op 11 and op 10) → Result1=0xFFFFFFFF, Result2=0x12345678, after 33 Busy cycles.
- Back-to-back and ignored Start:
  - launch 6×7, then 9×9 unsigned in the first IDLE cycle → 42 is visible, then 81 after 33 more cycles;
  - pulse Start mid-op with different operands → no effect on the result.
- Reset mid-operation: assert RESET at cycle 10 of a multiply → Busy=0 and Result1=Result2=0 on the next cycle. A following 5×5 multiply returns 25 normally.

Source files
------------

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: radix-2 shift-and-add multiply and restoring
// divide, one bit per cycle, with sign handling around an unsigned core.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    COMPUTING
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   result1_q, result1_d;
  logic [WIDTH-1:0]   result2_q, result2_d;

  logic               is_signed, sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     rem_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // One iteration of the core. In divide mode acc low half shifts the
  // dividend out at the top and the quotient in at the bottom.
  always_comb begin
    is_signed = ~MCycleOp[0];
    sign1     = is_signed & Operand1[WIDTH-1];
    sign2     = is_signed & Operand2[WIDTH-1];
    mag1      = sign1 ? -Operand1 : Operand1;
    mag2      = sign2 ? -Operand2 : Operand2;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    div_trial = {rem_q, acc_q[WIDTH-1]} - {2'b00, mcand_q};

    if (is_div_q) begin
      acc_step = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
      rem_step = div_trial[WIDTH+1] ? {rem_q[WIDTH-1:0], acc_q[WIDTH-1]} : div_trial[WIDTH:0];
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      rem_step = rem_q;
    end

    prod_fix = neg_res_q ? -acc_step : acc_step;
    if (div0_q) begin
      quo_fix = '1;
    end else begin
      quo_fix = neg_res_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    end
    rem_fix = neg_rem_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    result1_d = result1_q;
    result2_d = result2_q;
    Busy      = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          Busy      = 1'b1;
          is_div_d  = MCycleOp[1];
          neg_res_d = sign1 ^ sign2;
          neg_rem_d = sign1;
          div0_d    = (Operand2 == '0);
          acc_d     = {{WIDTH{1'b0}}, (MCycleOp[1] ? mag1 : mag2)};
          mcand_d   = MCycleOp[1] ? mag2 : mag1;
          rem_d     = '0;
          count_d   = '0;
          state_d   = COMPUTING;
        end
      end
      COMPUTING: begin
        Busy    = 1'b1;
        acc_d   = acc_step;
        rem_d   = rem_step;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          result1_d = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
          result2_d = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  assign Result1 = result1_q;
  assign Result2 = result2_q;

endmodule
